// File: rtl/hazard_sequencer_pkg.sv
// Shared encodings, state type and slot helpers for the hazard sequencer
// and its scoreboard.
package hazard_sequencer_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int         DRAIN_CYCLES = 3;
  localparam logic [4:0] ECALL_REG    = 5'd17;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
  } wslot_t;

  // A slot only produces a value worth waiting for if it really writes a non-x0 register.
  function automatic logic writes_reg(wslot_t s, logic [4:0] r);
    return s.v & s.rw & (s.rd != 5'd0) & (s.rd == r);
  endfunction

  function automatic logic [1:0] fwd_sel(wslot_t mem, wslot_t wb, logic [4:0] rs);
    if (writes_reg(mem, rs))     return FWD_MEM;
    else if (writes_reg(wb, rs)) return FWD_WB;
    else                         return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shadow copy of the EX/MEM/WB slots plus the register-match logic that
// feeds stall, forwarding and ID-bypass decisions.
module hazard_scoreboard
  import hazard_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_use_rs1,
  input  logic       i_id_use_rs2,
  input  logic [4:0] i_id_rd,
  input  logic       i_id_reg_write,
  input  logic       i_id_mem_read,
  output logic       o_load_use,
  output logic       o_x17_busy,
  output logic [1:0] o_fwd_a,
  output logic [1:0] o_fwd_b,
  output logic       o_bypass_rs1,
  output logic       o_bypass_rs2
);

  logic       r_ex_v;
  logic [4:0] r_ex_rd;
  logic       r_ex_rw;
  logic       r_ex_mr;
  logic [4:0] r_ex_rs1;
  logic [4:0] r_ex_rs2;
  wslot_t     r_mem;
  wslot_t     r_wb;
  wslot_t     w_ex;

  // Only valid bits are reset; a bubble clears EX fields so a dead slot never matches.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_v  <= 1'b0;
      r_mem.v <= 1'b0;
      r_wb.v  <= 1'b0;
    end else begin
      r_ex_v  <= i_load;
      r_mem.v <= r_ex_v;
      r_wb.v  <= r_mem.v;
    end
    r_ex_rd  <= i_load ? i_id_rd        : 5'd0;
    r_ex_rw  <= i_load ? i_id_reg_write : 1'b0;
    r_ex_mr  <= i_load ? i_id_mem_read  : 1'b0;
    r_ex_rs1 <= i_load ? i_id_rs1       : 5'd0;
    r_ex_rs2 <= i_load ? i_id_rs2       : 5'd0;
    r_mem.rd <= r_ex_rd;
    r_mem.rw <= r_ex_rw;
    r_wb.rd  <= r_mem.rd;
    r_wb.rw  <= r_mem.rw;
  end

  assign w_ex = {r_ex_v, r_ex_rd, r_ex_rw};

  assign o_load_use = i_id_valid & r_ex_mr &
                      ((i_id_use_rs1 & writes_reg(w_ex, i_id_rs1)) |
                       (i_id_use_rs2 & writes_reg(w_ex, i_id_rs2)));

  assign o_x17_busy = writes_reg(w_ex, ECALL_REG) | writes_reg(r_mem, ECALL_REG) |
                      writes_reg(r_wb, ECALL_REG);

  assign o_fwd_a      = fwd_sel(r_mem, r_wb, r_ex_rs1);
  assign o_fwd_b      = fwd_sel(r_mem, r_wb, r_ex_rs2);
  assign o_bypass_rs1 = i_id_use_rs1 & writes_reg(r_wb, i_id_rs1);
  assign o_bypass_rs2 = i_id_use_rs2 & writes_reg(r_wb, i_id_rs2);

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard control: load-use / ecall stalls, EX forwarding selects,
// ID bypass, and the ecall-driven drain-and-halt sequence.
module hazard_sequencer
  import hazard_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_reg_write,
  input  logic       id_mem_read,
  input  logic       id_is_ecall,
  input  logic       rf_x17_eq_10,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       id_ex_bubble,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       id_bypass_rs1,
  output logic       id_bypass_rs2,
  output logic       is_halted
);

  state_e     r_state;
  logic [1:0] r_cnt;
  logic       r_is_halted;

  logic       w_load_use;
  logic       w_x17_busy;
  logic       w_ecall_stall;
  logic       w_hold;
  logic       w_load;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_byp1;
  logic       w_byp2;

  hazard_scoreboard u_sb (
    .clk            (clk),
    .reset          (reset),
    .i_load         (w_load),
    .i_id_valid     (id_valid),
    .i_id_rs1       (id_rs1),
    .i_id_rs2       (id_rs2),
    .i_id_use_rs1   (id_use_rs1),
    .i_id_use_rs2   (id_use_rs2),
    .i_id_rd        (id_rd),
    .i_id_reg_write (id_reg_write),
    .i_id_mem_read  (id_mem_read),
    .o_load_use     (w_load_use),
    .o_x17_busy     (w_x17_busy),
    .o_fwd_a        (w_fwd_a),
    .o_fwd_b        (w_fwd_b),
    .o_bypass_rs1   (w_byp1),
    .o_bypass_rs2   (w_byp2)
  );

  assign w_ecall_stall = id_valid & id_is_ecall & w_x17_busy;
  assign w_hold        = (r_state != ST_RUN) | w_load_use | w_ecall_stall;
  assign w_load        = id_valid & ~w_hold & ~reset;

  // Reset overrides the combinational view so the pipeline runs cleanly out of reset.
  assign pc_write      = reset | ~w_hold;
  assign if_id_write   = reset | ~w_hold;
  assign id_ex_bubble  = ~reset & w_hold;
  assign fwd_a         = reset ? FWD_RF : w_fwd_a;
  assign fwd_b         = reset ? FWD_RF : w_fwd_b;
  assign id_bypass_rs1 = ~reset & w_byp1;
  assign id_bypass_rs2 = ~reset & w_byp2;
  assign is_halted     = r_is_halted;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_cnt       <= 2'd0;
      r_is_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (id_valid & id_is_ecall & ~w_ecall_stall & rf_x17_eq_10) begin
            r_state <= ST_DRAIN;
            r_cnt   <= 2'(DRAIN_CYCLES);
          end
        end
        ST_DRAIN: begin
          r_cnt <= r_cnt - 2'd1;
          if (r_cnt == 2'd1) begin
            r_state     <= ST_HALTED;
            r_is_halted <= 1'b1;
          end
        end
        ST_HALTED: r_state <= ST_HALTED;
        default:   r_state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: directed hazard scenarios followed by
// random instruction streams, all predicted by an instruction-level model.
module tb_hazard_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
  logic       id_is_ecall, rf_x17_eq_10;
  logic       pc_write, if_id_write, id_ex_bubble;
  logic [1:0] fwd_a, fwd_b;
  logic       id_bypass_rs1, id_bypass_rs2, is_halted;

  hazard_sequencer dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_is_ecall(id_is_ecall),
    .rf_x17_eq_10(rf_x17_eq_10), .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_bubble(id_ex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .id_bypass_rs1(id_bypass_rs1), .id_bypass_rs2(id_bypass_rs2), .is_halted(is_halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst, v, u1, u2, rw, mr, ec, x10;
    bit [4:0] rd, rs1, rs2;
  } stim_t;

  typedef struct {
    bit pc, ifid, bub, b1, b2, h, hk;
    bit [1:0] fa, fb;
  } exp_t;

  // One in-flight instruction as the model sees it.
  typedef struct {
    bit v, rw, mr;
    bit [4:0] rd, rs1, rs2;
  } instr_t;

  exp_t   q[$];
  instr_t pipe[3];          // 0 = EX, 1 = MEM, 2 = WB
  bit     halted_known = 0;
  bit     halted = 0;
  int     drain_left = 0;
  bit     draining = 0;
  int     n_chk = 0;
  int     n_fail = 0;

  task automatic cmp(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic bit produces(instr_t x, bit [4:0] r);
    return x.v && x.rw && x.rd != 0 && x.rd == r;
  endfunction

  function automatic bit [1:0] source_of(bit [4:0] r);
    if (produces(pipe[1], r)) return 2'b01;
    if (produces(pipe[2], r)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit stalls(stim_t s);
    bit lu, es;
    lu = s.v && pipe[0].mr &&
         ((s.u1 && produces(pipe[0], s.rs1)) || (s.u2 && produces(pipe[0], s.rs2)));
    es = s.v && s.ec && (produces(pipe[0], 17) || produces(pipe[1], 17) || produces(pipe[2], 17));
    return lu || es;
  endfunction

  function automatic exp_t predict(stim_t s);
    exp_t e;
    bit frozen;
    e.h  = halted;
    e.hk = halted_known;
    if (s.rst) begin
      e.pc = 1; e.ifid = 1; e.bub = 0; e.fa = 0; e.fb = 0; e.b1 = 0; e.b2 = 0;
      return e;
    end
    frozen = draining || halted || stalls(s);
    e.pc   = !frozen;
    e.ifid = !frozen;
    e.bub  = frozen;
    e.fa   = source_of(pipe[0].rs1);
    e.fb   = source_of(pipe[0].rs2);
    e.b1   = s.u1 && produces(pipe[2], s.rs1);
    e.b2   = s.u2 && produces(pipe[2], s.rs2);
    return e;
  endfunction

  task automatic advance(stim_t s);
    instr_t nop;
    bit frozen, ecall_stall;
    nop = '{default: 0};
    if (s.rst) begin
      pipe = '{nop, nop, nop};
      halted = 0; draining = 0; drain_left = 0; halted_known = 1;
      return;
    end
    frozen = draining || halted || stalls(s);
    ecall_stall = s.v && s.ec &&
                  (produces(pipe[0], 17) || produces(pipe[1], 17) || produces(pipe[2], 17));
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    if (s.v && !frozen) pipe[0] = '{v: 1, rw: s.rw, mr: s.mr, rd: s.rd, rs1: s.rs1, rs2: s.rs2};
    else                pipe[0] = nop;
    if (draining) begin
      drain_left--;
      if (drain_left == 0) begin draining = 0; halted = 1; end
    end else if (!halted && s.v && s.ec && !ecall_stall && s.x10) begin
      draining = 1; drain_left = 3;
    end
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    reset = s.rst; id_valid = s.v; id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd;
    id_use_rs1 = s.u1; id_use_rs2 = s.u2; id_reg_write = s.rw; id_mem_read = s.mr;
    id_is_ecall = s.ec; rf_x17_eq_10 = s.x10;
    e = predict(s);
    q.push_back(e);
    advance(s);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic stim_t rst_s();
    stim_t s;
    s = idle();
    s.rst = 1;
    return s;
  endfunction

  function automatic stim_t ins(bit [4:0] rd, bit [4:0] rs1, bit [4:0] rs2,
                                bit u1, bit u2, bit rw, bit mr);
    stim_t s;
    s = idle();
    s.v = 1; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2; s.rw = rw; s.mr = mr;
    return s;
  endfunction

  function automatic stim_t ecall(bit x10);
    stim_t s;
    s = idle();
    s.v = 1; s.ec = 1; s.x10 = x10;
    return s;
  endfunction

  function automatic bit [4:0] pick_reg();
    case ($urandom_range(0, 4))
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd2;
      3: return 5'd17;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  // Monitor: every cycle the DUT presents a response, compare it to the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("pc_write", pc_write, e.pc);
        cmp("if_id_write", if_id_write, e.ifid);
        cmp("id_ex_bubble", id_ex_bubble, e.bub);
        cmp("fwd_a", fwd_a, e.fa);
        cmp("fwd_b", fwd_b, e.fb);
        cmp("id_bypass_rs1", id_bypass_rs1, e.b1);
        cmp("id_bypass_rs2", id_bypass_rs2, e.b2);
        if (e.hk) cmp("is_halted", is_halted, e.h);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    reset = 1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_use_rs1 = 0;
    id_use_rs2 = 0; id_reg_write = 0; id_mem_read = 0; id_is_ecall = 0; rf_x17_eq_10 = 0;

    step(rst_s()); step(rst_s());
    #1 cmp("reset_pc_write", pc_write, 1);
    cmp("reset_bubble", id_ex_bubble, 0);
    step(idle());
    #1 cmp("reset_is_halted", is_halted, 0);

    // lw x5 then add x6,x5,x1
    step(ins(5, 1, 0, 1, 0, 1, 1));
    step(ins(6, 5, 1, 1, 1, 1, 0));
    #1 cmp("loaduse_pc_write", pc_write, 0);
    cmp("loaduse_bubble", id_ex_bubble, 1);
    step(ins(6, 5, 1, 1, 1, 1, 0));
    #1 cmp("loaduse_release", pc_write, 1);
    step(idle());
    #1 cmp("loaduse_fwd_a", fwd_a, 2);

    // MEM beats WB for the same register
    step(rst_s());
    step(ins(5, 0, 0, 1, 0, 1, 0));
    step(ins(5, 1, 2, 1, 1, 1, 0));
    step(ins(7, 5, 0, 1, 0, 1, 0));
    step(idle());
    #1 cmp("mem_priority_fwd_a", fwd_a, 1);

    // x0 writes never forward
    step(ins(0, 1, 1, 1, 1, 1, 0));
    step(ins(8, 0, 0, 1, 1, 1, 0));
    step(idle());
    #1 cmp("x0_fwd_a", fwd_a, 0);
    cmp("x0_no_stall", id_ex_bubble, 0);

    // ecall with a7 != 10 just passes
    step(ins(17, 0, 0, 1, 0, 1, 0));
    repeat (3) step(ecall(0));
    step(ecall(0));
    #1 cmp("ecall5_pass", pc_write, 1);
    repeat (5) step(idle());
    #1 cmp("ecall5_not_halted", is_halted, 0);

    // addi x17,x0,10 then ecall -> stall, drain, halt
    step(ins(17, 0, 0, 1, 0, 1, 0));
    for (int i = 0; i < 3; i++) begin
      step(ecall(1));
      #1 cmp("ecall_stall", pc_write, 0);
    end
    step(ecall(1));
    #1 cmp("ecall_accept", pc_write, 1);
    for (int i = 0; i < 3; i++) begin
      step(idle());
      #1 cmp("drain_bubble", id_ex_bubble, 1);
      cmp("drain_not_halted", is_halted, 0);
    end
    step(idle());
    #1 cmp("halted", is_halted, 1);
    step(ins(3, 1, 2, 1, 1, 1, 0));
    #1 cmp("halted_frozen", pc_write, 0);
    cmp("halted_held", is_halted, 1);

    // reset out of HALTED
    step(rst_s());
    step(idle());
    #1 cmp("unhalt_is_halted", is_halted, 0);
    cmp("unhalt_pc_write", pc_write, 1);
    cmp("unhalt_if_id_write", if_id_write, 1);

    // random streams
    for (int n = 0; n < 3000; n++) begin
      s = ins(pick_reg(), pick_reg(), pick_reg(), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
      s.v = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 9) == 0) begin
        s.ec = 1; s.rw = 0; s.mr = 0;
        s.x10 = ($urandom_range(0, 2) == 0);
      end
      s.rst = ((halted || draining) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 99) == 0));
      step(s);
    end

    repeat (3) @(negedge clk);
    cmp("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
